resp_serializer: RTL
====================

Name: resp_serializer

Overview:
- Downstream stage of the command decoder / register-file core.
- Captures one-cycle response pulses (OK, DATA, ERR) with their payload and serializes each into a byte frame for the UART transmitter over a valid/ready byte handshake.
- A one-entry pending buffer absorbs a response that arrives while a frame is still being sent.
- Responses arriving while the buffer is already full are dropped and counted.

Parameters:
- DROP_CNT_W, 8, width of the saturating dropped-response counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- resp_ok  input  1  1-cycle pulse; write acknowledged.
- resp_data  input  1  1-cycle pulse; read data available.
- resp_err  input  1  1-cycle pulse; command error.
- resp_addr  input  8  register address for OK/DATA.
- resp_data_byte  input  8  read data for DATA.
- resp_err_code  input  8  error code for ERR.
- tx_data  output  8  byte offered to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- busy  output  1  a frame is active (state != IDLE).
- drop_cnt  output  DROP_CNT_W  saturating count of dropped responses.

Behaviour:
- Reset values:
  - Asynchronous, while rst_n=0: tx_valid=0, tx_data=0x00, busy=0, drop_cnt=0, pending empty, state IDLE.
  - Reset mid-frame aborts the frame with no further bytes, and clears the pending entry.
- Frame formats, sent in order:
  - OK: 0x4B 'K', addr, 0x0A.
  - DATA: 0x44 'D', addr, data, 0x0A.
  - ERR: 0x45 'E', err_code, 0x0A.
- Capture:
  - Inputs are sampled on the pulse cycle only. Kind and payload go into a 24-bit record {kind, b1, b2}.
  - If more than one pulse is high in a cycle, priority is err > data > ok. The lower-priority pulses are ignored and not counted as drops.
- Handshake:
  - A byte transfers on the cycle where tx_valid && tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops mid-frame except on reset.
  - After a transfer, the next byte of the same frame is presented the following cycle; back-to-back transfers are allowed.
- Latency: a pulse at cycle N in IDLE gives tx_valid=1 with the opcode byte at N+1. busy=1 from N+1.
- FSM:
  - IDLE -> OP on a captured pulse.
  - OP -> B1 -> (B2 for DATA only) -> TERM, each step on a handshake.
  - TERM -> IDLE when the pending buffer is empty.
  - TERM -> OP when pending is valid: pending moves to active, next frame starts the cycle after the terminator transfer. There is no idle gap; tx_valid stays 1.
- Pending and drop rules:
  - Pulse while busy with pending empty: store in pending.
  - Pulse in the same cycle as the terminator transfer:
    - pending empty: the pulse becomes the next active frame;
    - pending valid: pending becomes active and the pulse takes the freed pending slot.
    - No drop in either case.
  - Pulse while busy, pending valid, and no terminator transfer that cycle: drop it; drop_cnt += 1, saturating at all-ones.
- Width: drop_cnt never wraps.

Optional Feature:
- Macro RESP_ASCII_HEX_EN.
- Defined:
  - Every payload byte (addr, data, err_code) is sent as two uppercase ASCII hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - The FSM gains a nibble-select bit. Frame lengths become OK 4, DATA 6, ERR 4 bytes.
  - Opcode and terminator bytes are unchanged.
- Undefined: raw binary payload; frame lengths OK 3, DATA 4, ERR 3 bytes.

Decomposition:
- Package uart_resp_pkg holds:
  - byte constants RESP_CH_K=0x4B, RESP_CH_D=0x44, RESP_CH_E=0x45, RESP_CH_LF=0x0A;
  - response-kind encoding (KIND_OK, KIND_DATA, KIND_ERR);
  - the FSM state encoding.
- Optional sub-module nib2ascii: combinational 4-bit to ASCII hex, instantiated only under RESP_ASCII_HEX_EN.
- All other logic stays in resp_serializer.

Test Plan:
- resp_data, addr=0x05, data=0xA7, tx_ready held 1 -> tx_valid from next cycle; bytes 0x44, 0x05, 0xA7, 0x0A on consecutive cycles; busy low after the last byte.
- resp_err, code=0x02, tx_ready toggled 1-0-0-1 -> tx_data held stable during stalls; bytes 0x45, 0x02, 0x0A; no duplicate or lost byte.
- resp_ok addr=0x0F, then resp_data addr=0x01 data=0x11 two cycles later, then a third pulse while both are held -> frames K(0x4B, 0x0F, 0x0A) then D(0x44, 0x01, 0x11, 0x0A) back-to-back; drop_cnt=1.
- Pulse coinciding with the terminator handshake, pending empty -> the new frame starts next cycle; drop_cnt unchanged.
- rst_n asserted after the second byte of a D frame -> tx_valid=0 immediately, drop_cnt=0; a new resp_ok after release gives a clean K frame.
- With RESP_ASCII_HEX_EN: resp_data addr=0x0B, data=0x3C -> 0x44, 0x30, 0x42, 0x33, 0x43, 0x0A.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// Shared encodings for the response serializer: frame bytes, response kinds, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_resp_pkg;

    localparam logic [7:0] RESP_CH_K  = 8'h4B;
    localparam logic [7:0] RESP_CH_D  = 8'h44;
    localparam logic [7:0] RESP_CH_E  = 8'h45;
    localparam logic [7:0] RESP_CH_LF = 8'h0A;

    // The kind code is the opcode byte itself, so it is sent directly.
    typedef enum logic [7:0] {
        KIND_OK   = RESP_CH_K,
        KIND_DATA = RESP_CH_D,
        KIND_ERR  = RESP_CH_E
    } resp_kind_t;

    typedef struct packed {
        resp_kind_t kind;
        logic [7:0] b1;
        logic [7:0] b2;
    } resp_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_B1,
        ST_B2,
        ST_TERM
    } state_t;

endpackage

// File: rtl/nib2ascii.sv
// Converts a 4-bit nibble to its uppercase ASCII hex character.
// Latency: combinational.
// Backpressure: n/a.
module nib2ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    assign ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

endmodule

// File: rtl/resp_serializer.sv
// Serializes OK/DATA/ERR response pulses into byte frames; RESP_ASCII_HEX_EN sends payload as hex text.
// Latency: pulse at cycle N in idle presents the opcode byte at N+1; back-to-back frames have no gap.
// Backpressure: tx_data held while tx_ready=0; one pending slot, further pulses dropped and counted.
module resp_serializer
    import uart_resp_pkg::*;
#(
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  resp_ok,
    input  logic                  resp_data,
    input  logic                  resp_err,
    input  logic [7:0]            resp_addr,
    input  logic [7:0]            resp_data_byte,
    input  logic [7:0]            resp_err_code,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t                  state, state_nxt;
    resp_rec_t               act, act_nxt, pend, pend_nxt, new_rec;
    logic                    pend_vld, pend_vld_nxt;
    logic [DROP_CNT_W-1:0]   drop_nxt;
    logic                    pulse, xfer, pay_done;
    logic [7:0]              pay_byte, pay_out;

    assign pulse    = resp_ok | resp_data | resp_err;
    assign tx_valid = (state != ST_IDLE);
    assign busy     = tx_valid;
    assign xfer     = tx_valid & tx_ready;

    always_comb begin
        new_rec = '{kind: KIND_OK, b1: resp_addr, b2: 8'h00};
        if (resp_err)
            new_rec = '{kind: KIND_ERR, b1: resp_err_code, b2: 8'h00};
        else if (resp_data)
            new_rec = '{kind: KIND_DATA, b1: resp_addr, b2: resp_data_byte};
    end

    assign pay_byte = (state == ST_B2) ? act.b2 : act.b1;

`ifdef RESP_ASCII_HEX_EN
    logic       nib, nib_nxt;
    logic [7:0] hex_char;

    nib2ascii u_nib2ascii (
        .nib   (nib ? pay_byte[3:0] : pay_byte[7:4]),
        .ascii (hex_char)
    );

    assign pay_out  = hex_char;
    assign pay_done = nib;

    always_comb begin
        nib_nxt = nib;
        if (xfer && (state == ST_B1 || state == ST_B2))
            nib_nxt = ~nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nib <= 1'b0;
        else        nib <= nib_nxt;
    end
`else
    assign pay_out  = pay_byte;
    assign pay_done = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        act_nxt      = act;
        pend_nxt     = pend;
        pend_vld_nxt = pend_vld;
        drop_nxt     = drop_cnt;
        case (state)
            ST_IDLE: if (pulse) begin
                act_nxt   = new_rec;
                state_nxt = ST_OP;
            end
            ST_OP:   if (xfer) state_nxt = ST_B1;
            ST_B1:   if (xfer && pay_done)
                state_nxt = (act.kind == KIND_DATA) ? ST_B2 : ST_TERM;
            ST_B2:   if (xfer && pay_done) state_nxt = ST_TERM;
            ST_TERM: if (xfer) begin
                if (pend_vld) begin
                    act_nxt      = pend;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = ST_OP;
                end else begin
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A pulse during a frame: it either rides the terminator handoff, fills the slot, or is dropped.
        if (pulse && state != ST_IDLE) begin
            if (state == ST_TERM && xfer) begin
                if (pend_vld) begin
                    pend_nxt     = new_rec;
                    pend_vld_nxt = 1'b1;
                end else begin
                    act_nxt   = new_rec;
                    state_nxt = ST_OP;
                end
            end else if (!pend_vld) begin
                pend_nxt     = new_rec;
                pend_vld_nxt = 1'b1;
            end else if (drop_cnt != '1) begin
                drop_nxt = drop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_OP:   tx_data = act.kind;
            ST_B1,
            ST_B2:   tx_data = pay_out;
            ST_TERM: tx_data = RESP_CH_LF;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            act      <= '{kind: KIND_OK, b1: 8'h00, b2: 8'h00};
            pend     <= '{kind: KIND_OK, b1: 8'h00, b2: 8'h00};
            pend_vld <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            act      <= act_nxt;
            pend     <= pend_nxt;
            pend_vld <= pend_vld_nxt;
            drop_cnt <= drop_nxt;
        end
    end

endmodule
